adex_neuron_array: RTL and testbench

//  N_CH independent adaptive exponential integrate-and-fire (AdEx) neurons, updated in parallel once per en strobe.

---
 rtl/adex_neuron_array.sv | 125 ++++++++++++
 tb/tb_adex_neuron_array.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adex_neuron_array.sv
// Array of N_CH independent adaptive exponential integrate-and-fire neurons.
// All channels advance together on each en strobe; spike, V and w outputs are registered.
module adex_neuron_array #(
  parameter int N_CH        = 4,
  parameter int W           = 8,
  parameter int V_RESET     = 0,
  parameter int V_T         = 128,
  parameter int LEAK_SHIFT  = 3,
  parameter int EXP_SHIFT   = 4,
  parameter int A_SHIFT     = 5,
  parameter int TAU_W_SHIFT = 4,
  parameter int B_INC       = 16,
  parameter int REFRACT     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              adapt_en,
  input  logic [N_CH*W-1:0] current,
  input  logic [W-1:0]      v_peak,
  output logic [N_CH-1:0]   spike,
  output logic [N_CH*W-1:0] state,
  output logic [N_CH*W-1:0] adapt
);

  localparam int SW = W + 3;
  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  typedef logic signed [SW-1:0] sval_t;

  typedef struct packed {
    logic [W-1:0]  v;
    logic [W-1:0]  w;
    logic [RW-1:0] r;
    logic          spk;
  } ch_t;

  localparam sval_t MAX_S = sval_t'((1 << W) - 1);

  ch_t ch_q [N_CH];
  ch_t ch_d [N_CH];

  function automatic sval_t ext(input logic [W-1:0] x);
    return $signed({3'b000, x});
  endfunction

  // Clamp a signed intermediate back into the unsigned W-bit range.
  function automatic logic [W-1:0] sat(input sval_t x);
    if (x[SW-1])       return '0;
    else if (x > MAX_S) return '1;
    else               return x[W-1:0];
  endfunction

  function automatic ch_t step_ch(input ch_t s, input logic [W-1:0] i_in,
                                  input logic [W-1:0] vp, input logic ad);
    sval_t        v_s;
    sval_t        w_s;
    sval_t        exp_s;
    logic [W-1:0] vn;
    logic [W-1:0] wn;
    int           k;
    ch_t          n;
    v_s   = ext(s.v);
    w_s   = ad ? ext(s.w) : '0;
    exp_s = '0;
    vn    = '0;
    wn    = '0;
    n     = s;
    n.spk = 1'b0;
    if (int'(s.v) > V_T) begin
      k = (int'(s.v) - V_T) >> EXP_SHIFT;
      if (k > W - 1) k = W - 1;
      exp_s = sval_t'(1) << k;
    end
    if (s.r != '0) begin
      n.v = W'(V_RESET);
      n.r = s.r - 1'b1;
      n.w = sat(w_s - (w_s >>> TAU_W_SHIFT));
    end else begin
      vn = sat(v_s + ext(i_in) - (v_s >>> LEAK_SHIFT) - w_s + exp_s);
      // Adaptation is driven by the pre-update membrane value.
      wn = sat(w_s - (w_s >>> TAU_W_SHIFT) + (v_s >>> A_SHIFT));
      if (vn >= vp) begin
        n.spk = 1'b1;
        n.v   = W'(V_RESET);
        n.w   = sat(ext(wn) + sval_t'(B_INC));
        n.r   = RW'(REFRACT);
      end else begin
        n.v = vn;
        n.w = wn;
      end
    end
    if (!ad) n.w = '0;
    return n;
  endfunction

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      // NOTE: every field gets a default before any branch, so no latch can be inferred.
      ch_d[c]     = ch_q[c];
      ch_d[c].spk = 1'b0;
      if (!adapt_en) ch_d[c].w = '0;
      if (en) ch_d[c] = step_ch(ch_q[c], current[c*W +: W], v_peak, adapt_en);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these are a handful of flops, not a RAM, so resetting the whole array is cheap and correct.
      for (int c = 0; c < N_CH; c++)
        ch_q[c] <= '{v: W'(V_RESET), w: '0, r: '0, spk: 1'b0};
    end else begin
      // NOTE: non-blocking so every channel samples the pre-edge state.
      for (int c = 0; c < N_CH; c++)
        ch_q[c] <= ch_d[c];
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_out
    assign spike[c]         = ch_q[c].spk;
    assign state[c*W +: W]  = ch_q[c].v;
    assign adapt[c*W +: W]  = ch_q[c].w;
  end

endmodule

// File: tb/tb_adex_neuron_array.sv
// Self-checking bench for adex_neuron_array: hand-computed vector table plus a
// behavioural model feeding a scoreboard queue for the multi-cycle sequences.
module tb_adex_neuron_array;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           adapt_en = 1'b0;
  logic [N*W-1:0] current = '0;
  logic [W-1:0]   v_peak = '0;
  logic [N-1:0]   spike;
  logic [N*W-1:0] state;
  logic [N*W-1:0] adapt;

  adex_neuron_array dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .adapt_en (adapt_en),
    .current  (current),
    .v_peak   (v_peak),
    .spike    (spike),
    .state    (state),
    .adapt    (adapt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit rst;
    bit en;
    bit ad;
    int cur0;
    int vp;
    int v0;
    bit spk0;
    int w0;
  } vec_t;

  typedef struct {
    logic [N*W-1:0] st;
    logic [N*W-1:0] ad;
    logic [N-1:0]   sp;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  int m_v[N];
  int m_w[N];
  int m_r[N];
  bit m_spk[N];
  int cur_a[N];
  int step_no;
  int spk_t[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int sat8(input int x);
    if (x < 0) return 0;
    if (x > 255) return 255;
    return x;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      m_v[c] = 0; m_w[c] = 0; m_r[c] = 0; m_spk[c] = 0;
    end
  endfunction

  function automatic void model_step(input bit e, input bit ad, input int vp);
    int wt, ex, k, vn, wn;
    for (int c = 0; c < N; c++) begin
      if (!e) begin
        m_spk[c] = 0;
        if (!ad) m_w[c] = 0;
      end else if (m_r[c] != 0) begin
        m_v[c] = 0;
        m_r[c] = m_r[c] - 1;
        m_w[c] = ad ? m_w[c] - m_w[c] / 16 : 0;
        m_spk[c] = 0;
      end else begin
        wt = ad ? m_w[c] : 0;
        ex = 0;
        if (m_v[c] > 128) begin
          k = (m_v[c] - 128) / 16;
          if (k > 7) k = 7;
          ex = 1 << k;
        end
        vn = sat8(m_v[c] + cur_a[c] - m_v[c] / 8 - wt + ex);
        wn = sat8(wt - wt / 16 + m_v[c] / 32);
        if (vn >= vp) begin
          m_spk[c] = 1; m_v[c] = 0; m_r[c] = 3;
          m_w[c] = ad ? sat8(wn + 16) : 0;
        end else begin
          m_spk[c] = 0; m_v[c] = vn; m_w[c] = ad ? wn : 0;
        end
      end
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_state", state, 0);
    check("rst_adapt", adapt, 0);
    check("rst_spike", spike, 0);
    model_reset();
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step(input bit e, input bit ad, input int vp, input string tag);
    exp_t x;
    exp_t got;
    en       = e;
    adapt_en = ad;
    v_peak   = 8'(vp);
    for (int c = 0; c < N; c++) current[c*W +: W] = 8'(cur_a[c]);
    model_step(e, ad, vp);
    for (int c = 0; c < N; c++) begin
      x.st[c*W +: W] = 8'(m_v[c]);
      x.ad[c*W +: W] = 8'(m_w[c]);
      x.sp[c]        = m_spk[c];
    end
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      got = sb_q.pop_front();
      check($sformatf("%s_state@%0d", tag, step_no), state, got.st);
      check($sformatf("%s_adapt@%0d", tag, step_no), adapt, got.ad);
      check($sformatf("%s_spike@%0d", tag, step_no), spike, got.sp);
    end
    if (spike[0]) spk_t.push_back(step_no);
    step_no++;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    if (v.rst) begin
      do_reset();
    end else begin
      en       = v.en;
      adapt_en = v.ad;
      current  = {24'd0, 8'(v.cur0)};
      v_peak   = 8'(v.vp);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_v0", idx), state[7:0], v.v0);
      check($sformatf("vec%0d_spk0", idx), spike[0], v.spk0);
      check($sformatf("vec%0d_w0", idx), adapt[7:0], v.w0);
      check($sformatf("vec%0d_others", idx), {state[31:8], spike[3:1]}, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Channel 0 at I=40, v_peak=200: rise, fire, three refractory steps, then integrate again.
    vecs.push_back('{1, 0, 0, 0,   0,   0,   0, 0});
    vecs.push_back('{0, 1, 0, 40,  200, 40,  0, 0});
    vecs.push_back('{0, 1, 0, 40,  200, 75,  0, 0});
    vecs.push_back('{0, 1, 0, 40,  200, 106, 0, 0});
    vecs.push_back('{0, 1, 0, 40,  200, 133, 0, 0});
    vecs.push_back('{0, 1, 0, 40,  200, 158, 0, 0});
    vecs.push_back('{0, 1, 0, 40,  200, 181, 0, 0});
    vecs.push_back('{0, 1, 0, 40,  200, 0,   1, 0});
    vecs.push_back('{0, 1, 0, 40,  200, 0,   0, 0});
    vecs.push_back('{0, 1, 0, 40,  200, 0,   0, 0});
    vecs.push_back('{0, 1, 0, 40,  200, 0,   0, 0});
    vecs.push_back('{0, 1, 0, 40,  200, 40,  0, 0});
    vecs.push_back('{0, 0, 0, 40,  200, 40,  0, 0});
    vecs.push_back('{0, 1, 0, 40,  200, 75,  0, 0});
    // Exponential term at V=192 (k=4 -> +16), then saturation at I=255.
    vecs.push_back('{1, 0, 0, 0,   0,   0,   0, 0});
    vecs.push_back('{0, 1, 0, 192, 255, 192, 0, 0});
    vecs.push_back('{0, 1, 0, 0,   255, 184, 0, 0});
    vecs.push_back('{0, 1, 0, 255, 255, 0,   1, 0});
    vecs.push_back('{0, 1, 0, 255, 255, 0,   0, 0});
    vecs.push_back('{0, 1, 0, 255, 255, 0,   0, 0});
    vecs.push_back('{0, 1, 0, 255, 255, 0,   0, 0});
    vecs.push_back('{0, 1, 0, 255, 255, 0,   1, 0});

    step_no = 0;
    for (int i = 0; i < N; i++) cur_a[i] = 0;
    model_reset();

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

    // Quiescent: zero current leaves everything at reset values.
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 0, 200, "idle");

    // Adaptation lengthens (never shortens) the inter-spike interval.
    do_reset();
    cur_a = '{120, 0, 0, 0};
    spk_t.delete();
    for (int i = 0; i < 30; i++) step(1, 1, 200, "adapt");
    check("isi_count_ge5", spk_t.size() >= 5, 1);
    if (spk_t.size() >= 5)
      for (int i = 2; i < 5; i++)
        check($sformatf("isi_nondec%0d", i),
              (spk_t[i] - spk_t[i-1]) >= (spk_t[i-1] - spk_t[i-2]), 1);

    // en low mid-integration and mid-refractory freezes V, w and the refractory count.
    do_reset();
    cur_a = '{40, 120, 0, 70};
    for (int i = 0; i < 2; i++) step(1, 1, 200, "en_a");
    for (int i = 0; i < 3; i++) step(0, 1, 200, "en_off");
    for (int i = 0; i < 6; i++) step(1, 1, 200, "en_b");

    // Reset right after a spike edge: channel 0 refractory with w>0.
    do_reset();
    cur_a = '{120, 0, 0, 0};
    step(1, 1, 200, "pre_rst");
    step(1, 1, 200, "pre_rst");
    check("pre_rst_spike0", spike[0], 1);
    #2;
    do_reset();
    spk_t.delete();
    for (int i = 0; i < 4; i++) step(1, 1, 200, "post_rst");
    check("post_rst_fires", spk_t.size(), 1);

    // Randomised traffic including v_peak=0, v_peak=255 and adapt_en toggling.
    do_reset();
    for (int blk = 0; blk < 8; blk++) begin
      bit ad;
      int vp;
      ad = blk[0];
      case (blk % 4)
        0:       vp = 0;
        1:       vp = 255;
        2:       vp = 150;
        default: vp = int'($urandom_range(255));
      endcase
      for (int i = 0; i < 25; i++) begin
        for (int c = 0; c < N; c++) cur_a[c] = int'($urandom_range(255));
        step(($urandom_range(3) != 0), ad, vp, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
